// File: rtl/pb_debounce_toggle.sv
// Pushbutton conditioner: per-channel two-flop synchronizer, debounce counter,
// edge detector producing registered press/release strobes, and an LED driver.
module pb_debounce_toggle #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] pb,
    input  logic             mode,
    output logic [N_BTN-1:0] led,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_chan
            logic             s1_reg;
            logic             s2_reg;
            logic             stable_reg;
            logic             stable_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             tog_reg;
            logic             tog_next;
            logic             led_reg;
            logic             led_next;
            logic             press_reg;
            logic             press_next;
            logic             release_reg;
            logic             release_next;

            // A mismatch must persist for DEBOUNCE_CYCLES edges before the
            // new level is accepted; any return to agreement restarts the count.
            always_comb begin
                cnt_next     = '0;
                stable_next  = stable_reg;
                press_next   = 1'b0;
                release_next = 1'b0;
                if (s2_reg != stable_reg) begin
                    if (cnt_reg == CNT_MAX) begin
                        stable_next  = s2_reg;
                        press_next   = s2_reg;
                        release_next = ~s2_reg;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                tog_next = tog_reg ^ press_next;
                led_next = mode ? tog_next : stable_next;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_reg      <= 1'b0;
                    s2_reg      <= 1'b0;
                    stable_reg  <= 1'b0;
                    cnt_reg     <= '0;
                    tog_reg     <= 1'b0;
                    led_reg     <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    s1_reg      <= pb[gi];
                    s2_reg      <= s1_reg;
                    stable_reg  <= stable_next;
                    cnt_reg     <= cnt_next;
                    tog_reg     <= tog_next;
                    led_reg     <= led_next;
                    press_reg   <= press_next;
                    release_reg <= release_next;
                end
            end

            assign led[gi]           = led_reg;
            assign press_pulse[gi]   = press_reg;
            assign release_pulse[gi] = release_reg;
        end
    endgenerate

endmodule
